// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-ported instruction bank between fetch and loader.
// Define IMEM_ARB_STARVE_EN to cap loader grant streaks while fetch is waiting.
module imem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic        if_fault,
  output logic        if_stall,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [7:0]  ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_gnt,
  output logic        ld_done,
  output logic [31:0] ld_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
      $error("imem_arbiter: MEM_LAT must be 1..4");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve
      $error("imem_arbiter: STARVE_MAX must fit the 3-bit streak");
    end
  endgenerate

  state_e     state_q;
  logic [1:0] cnt_q;
  logic       owner_ld_q;

  logic       idle;
  logic       fetch_force;
  logic       if_mis;

  assign idle   = (state_q == IDLE);
  assign if_mis = |if_addr[1:0];

`ifdef IMEM_ARB_STARVE_EN
  logic [2:0] streak_q;

  assign fetch_force = if_req & ld_req &
                       (streak_q == 3'(STARVE_MAX));

  // streak counts loader wins while fetch is actually waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= 3'd0;
    end else if (!if_req || if_gnt) begin
      streak_q <= 3'd0;
    end else if (ld_gnt) begin
      streak_q <= streak_q + 3'd1;
    end
  end
`else
  assign fetch_force = 1'b0;
`endif

  assign ld_gnt   = idle & ld_req & ~fetch_force;
  assign if_gnt   = idle & if_req & ~ld_gnt;
  assign if_stall = ~idle | (if_req & ~if_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      owner_ld_q <= 1'b0;
      if_valid   <= 1'b0;
      if_inst    <= 32'd0;
      if_fault   <= 1'b0;
      ld_done    <= 1'b0;
      ld_rdata   <= 32'd0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= 8'd0;
      mem_wdata  <= 32'd0;
    end else begin
      if_valid <= 1'b0;
      ld_done  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ld_gnt) begin
            mem_addr <= ld_addr & 8'hFC;
            if (ld_we) begin
              mem_wdata <= ld_wdata;
              mem_write <= 1'b1;
              state_q   <= WR;
            end else begin
              mem_read   <= 1'b1;
              cnt_q      <= LAT_M1;
              owner_ld_q <= 1'b1;
              state_q    <= RD;
            end
          end else if (if_gnt) begin
            if (if_mis) begin
              // misaligned: answered from IDLE, bank untouched
              if_valid <= 1'b1;
              if_fault <= 1'b1;
              if_inst  <= 32'd0;
            end else begin
              mem_addr   <= if_addr;
              mem_read   <= 1'b1;
              cnt_q      <= LAT_M1;
              owner_ld_q <= 1'b0;
              state_q    <= RD;
            end
          end
        end
        RD: begin
          if (cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
          end else begin
            mem_read <= 1'b0;
            state_q  <= IDLE;
            if (owner_ld_q) begin
              ld_rdata <= mem_rdata;
              ld_done  <= 1'b1;
            end else begin
              if_inst  <= mem_rdata;
              if_fault <= 1'b0;
              if_valid <= 1'b1;
            end
          end
        end
        WR: begin
          mem_write <= 1'b0;
          ld_done   <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule
